ahb_sram_slave: RTL and testbench
=================================

Name: ahb_sram_slave

Overview:
AHB slave memory that sits directly downstream of ahb_master. It consumes the master's address/control/write-data outputs and returns HRDATA, HREADY and HRESP to the master's i_h* inputs. It gives the PicoRV32 → adapter → FreeAHB path a real target for simulation and bring-up. Transfers run with a programmable number of wait states, byte-lane writes and address-range checking.

Parameters:
BASE_ADDR, 32'h8000_0000, byte address of word 0
DEPTH, 1024, number of 32-bit words; power of two
WAIT_STATES, 0, HREADY-low cycles per data phase; range 0..15

Ports:
i_hclk  in  1  clock; all logic on the rising edge
i_hreset  in  1  synchronous, active-high reset
i_hsel  in  1  slave select
i_haddr  in  32  address-phase address
i_htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
i_hwrite  in  1  1 = write
i_hsize  in  3  0 byte, 1 halfword, 2 word
i_hburst  in  3  burst type; not decoded, only HTRANS matters
i_hwdata  in  32  write data, valid in the data phase
o_hrdata  out  32  read data
o_hready  out  1  data-phase completion
o_hresp  out  2  00 OKAY, 01 ERROR

Behaviour:
- Interface: one clock, i_hclk. Reset is synchronous and active-high on i_hreset.
- Reset values: o_hready=1, o_hresp=00, o_hrdata=0, FSM=IDLE. Any pending write is dropped. Memory contents are not reset.
- Address-phase sample: on an edge with o_hready=1, i_hsel=1 and i_htrans[1]=1, capture haddr, hwrite and hsize.
- No sample: IDLE, BUSY or i_hsel=0 with o_hready=1 gives a zero-wait OKAY. The FSM stays in or returns to IDLE.
- FSM states: IDLE, WAIT, DATA, ERR1, ERR2.
- IDLE → WAIT on a sampled valid transfer when WAIT_STATES>0; the counter loads WAIT_STATES-1.
- IDLE → DATA when WAIT_STATES=0.
- WAIT: o_hready=0, o_hresp=00. Decrement the counter; go to DATA when it reaches 0.
- DATA: o_hready=1, o_hresp=00.
  - Read: o_hrdata holds the addressed word, all 4 lanes.
  - Write: lanes selected by hsize/haddr[1:0] (little-endian) are written from i_hwdata at the closing edge.
  - A new address phase may be sampled on that same edge (pipelining). Next state is WAIT, DATA, ERR1 or IDLE accordingly.
- Data-phase latency is WAIT_STATES+1 cycles per beat. A back-to-back SEQ burst at WAIT_STATES=0 completes one beat per cycle.
- Read-after-write hazard: a read whose address phase coincides with the previous write's closing edge, to the same word, returns the merged new bytes (forwarding). The read must never see stale data.
- Byte lanes: hsize=0 uses lane haddr[1:0]. hsize=1 uses lanes {haddr[1],0}..+1. hsize=2 uses all lanes.
- Word index: (haddr-BASE_ADDR)>>2. The address is in range iff BASE_ADDR ≤ haddr < BASE_ADDR+4*DEPTH.
- Invalid transfer: out of range, hsize>2, or misaligned (hsize=1 with haddr[0]=1, hsize=2 with haddr[1:0]≠0). Handling depends on the optional feature below.
- Write data is sampled only at the closing edge of the data phase (o_hready=1), never during WAIT.
- Reset asserted mid-burst or mid-WAIT: outputs return to reset values on the next edge and no write is committed.

Optional Feature:
AHB_SLAVE_ERR_RESP_EN
- Defined: an invalid transfer goes to ERR1 (o_hready=0, o_hresp=01), then ERR2 (o_hready=1, o_hresp=01). Memory is not written.
  - The address phase on the ERR2 closing edge is sampled normally.
- Undefined: invalid transfers complete as normal OKAY with the same wait states. Invalid writes are discarded. Invalid reads return 32'h0. hsize>2 is treated as word.

Test Plan:
- Word write then read, WAIT_STATES=0: NONSEQ write 0x8000_0000 with F0FF0FAA, then NONSEQ read of the same address → o_hrdata=F0FF0FAA, o_hresp=00, no HREADY-low cycles. The read is back-to-back, so this also exercises forwarding.
- Byte write: word 0x8000_0004 preloaded 11223344; write byte 0x8000_0006 with hwdata 00AA0000 → a later read returns 11AA3344.
- Wait states, WAIT_STATES=3: read → o_hready low exactly 3 cycles, then high 1 cycle with data. A 4-beat INCR SEQ burst → 16 cycles total.
- Error with AHB_SLAVE_ERR_RESP_EN: write to 0x8000_1000 (DEPTH=1024) → cycle 1 hready=0/hresp=01, cycle 2 hready=1/hresp=01, memory unchanged. Without the macro → OKAY, and a read of the same address returns 0.
- Idle/busy/unselected: IDLE, BUSY, or i_hsel=0 transfers → o_hready=1, o_hresp=00 every cycle, no memory change.
- Reset mid-transfer: assert i_hreset during the 2nd WAIT cycle of a write → next cycle o_hready=1, o_hresp=00, and the target word keeps its old value.

Source files
------------

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM target with programmable wait states,
// byte-lane writes, address-range checking and read-after-write forwarding.
// Optional feature macro: AHB_SLAVE_ERR_RESP_EN
//   defined   -> invalid transfers get a two-cycle ERROR response
//   undefined -> invalid transfers complete OKAY; writes dropped, reads return 0
module ahb_sram_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic        i_hsel,
    input  logic [31:0] i_haddr,
    input  logic [1:0]  i_htrans,
    input  logic        i_hwrite,
    input  logic [2:0]  i_hsize,
    input  logic [2:0]  i_hburst,
    input  logic [31:0] i_hwdata,
    output logic [31:0] o_hrdata,
    output logic        o_hready,
    output logic [1:0]  o_hresp
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [32:0] LIMIT    = 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [3:0]      w_cnt_nxt;

    // Captured address-phase attributes of the transfer in its data phase
    logic [AW-1:0]   r_idx;
    logic [3:0]      r_be;
    logic            r_write;
    logic            r_valid;

    logic [31:0]     r_hrdata;
    logic [31:0]     r_mem [DEPTH];

    logic            w_hready;
    logic            w_sample;
    logic [31:0]     w_off;
    logic            w_in_range;
    logic            w_size_ok;
    logic            w_misalign;
    logic            w_in_valid;
    logic [3:0]      w_in_be;
    logic [AW-1:0]   w_in_idx;
    logic            w_commit;
    logic [AW-1:0]   w_rd_idx;
    logic            w_rd_ok;
    logic [31:0]     w_rd_word;
    logic            w_unused;

    // Response outputs are a pure function of the FSM state
    always_comb begin
        w_hready = 1'b1;
        o_hresp  = 2'b00;
        case (r_state)
            ST_WAIT: w_hready = 1'b0;
            ST_ERR1: begin
                w_hready = 1'b0;
                o_hresp  = 2'b01;
            end
            ST_ERR2: o_hresp = 2'b01;
            default: w_hready = 1'b1;
        endcase
    end

    assign o_hready = w_hready;
    assign o_hrdata = r_hrdata;
    assign w_sample = w_hready & i_hsel & i_htrans[1];

    // Address-phase decode: range, alignment, byte lanes and word index
    always_comb begin
        w_off      = i_haddr - BASE_ADDR;
        w_in_range = (i_haddr >= BASE_ADDR) && ({1'b0, w_off} < LIMIT);
        w_size_ok  = (i_hsize <= 3'd2);
        w_in_idx   = w_off[AW+1:2];
        case (i_hsize)
            3'd0: begin
                w_misalign = 1'b0;
                w_in_be    = 4'b0001 << i_haddr[1:0];
            end
            3'd1: begin
                w_misalign = i_haddr[0];
                w_in_be    = i_haddr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_misalign = (i_haddr[1:0] != 2'b00);
                w_in_be    = 4'b1111;
            end
        endcase
`ifdef AHB_SLAVE_ERR_RESP_EN
        w_in_valid = w_in_range & w_size_ok & ~w_misalign;
`else
        // Oversized transfers are handled as word transfers
        w_in_valid = w_in_range & ~w_misalign;
`endif
    end

    // Next-state and wait counter
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_DATA;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_ERR1: w_state_nxt = ST_ERR2;
            default: begin
                if (w_sample) begin
`ifdef AHB_SLAVE_ERR_RESP_EN
                    if (!w_in_valid) begin
                        w_state_nxt = ST_ERR1;
                    end else
`endif
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = ST_WAIT;
                        w_cnt_nxt   = CNT_LOAD;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
        endcase
    end

    // State register and wait counter
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Capture address-phase attributes when a transfer is accepted
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_idx   <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_valid <= 1'b0;
        end else if (w_sample) begin
            r_idx   <= w_in_idx;
            r_be    <= w_in_be;
            r_write <= i_hwrite;
            r_valid <= w_in_valid;
        end
    end

    // Write data is only taken on the closing edge of a valid write data phase
    assign w_commit = (r_state == ST_DATA) & r_write & r_valid & ~i_hreset;

    // Byte-lane write into the array
    always_ff @(posedge i_hclk) begin
        if (w_commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
                end
            end
        end
    end

    // Read source: a newly sampled transfer when entering DATA straight from
    // the address phase, otherwise the captured one leaving WAIT. Lanes
    // being committed on this same edge are forwarded so the read is never stale.
    always_comb begin
        w_rd_idx  = w_sample ? w_in_idx : r_idx;
        w_rd_ok   = w_sample ? (w_in_valid & ~i_hwrite) : (r_valid & ~r_write);
        w_rd_word = r_mem[w_rd_idx];
        if (w_commit && (w_rd_idx == r_idx)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_be[b]) begin
                    w_rd_word[8*b +: 8] = i_hwdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register, loaded on entry to the data phase
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            r_hrdata <= '0;
        end else if (w_state_nxt == ST_DATA) begin
            r_hrdata <= w_rd_ok ? w_rd_word : '0;
        end
    end

    // Burst type and the SEQ/NONSEQ distinction are intentionally ignored
    assign w_unused = ^{i_hburst, i_htrans[0], w_off, w_size_ok};

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: one instance with zero wait states
// and one with three, each driven by a pipelined AHB master task and checked
// against a word-array reference model.
module tb_ahb_sram_slave;

    localparam longint BASE  = 64'h8000_0000;
    localparam int     DEPTH = 1024;

`ifdef AHB_SLAVE_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } xfer_t;

    logic        clk = 1'b0;
    logic        hreset;
    logic        hsel   [2];
    logic [31:0] haddr  [2];
    logic [1:0]  htrans [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [2:0]  hburst [2];
    logic [31:0] hwdata [2];
    logic [31:0] hrdata [2];
    logic        hready [2];
    logic [1:0]  hresp  [2];

    int          n_assert = 0;
    int          n_fail   = 0;
    int          ws_of [2] = '{0, 3};
    logic [31:0] mm [2][DEPTH];
    xfer_t       q [$];
    int          data_cycles;
    logic [31:0] last_rd;

    always #5 clk = ~clk;

    ahb_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .WAIT_STATES(0)) u_dut0 (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel[0]), .i_haddr(haddr[0]),
        .i_htrans(htrans[0]), .i_hwrite(hwrite[0]), .i_hsize(hsize[0]),
        .i_hburst(hburst[0]), .i_hwdata(hwdata[0]), .o_hrdata(hrdata[0]),
        .o_hready(hready[0]), .o_hresp(hresp[0])
    );

    ahb_sram_slave #(.BASE_ADDR(32'h8000_0000), .DEPTH(1024), .WAIT_STATES(3)) u_dut1 (
        .i_hclk(clk), .i_hreset(hreset), .i_hsel(hsel[1]), .i_haddr(haddr[1]),
        .i_htrans(htrans[1]), .i_hwrite(hwrite[1]), .i_hsize(hsize[1]),
        .i_hburst(hburst[1]), .i_hwdata(hwdata[1]), .o_hrdata(hrdata[1]),
        .o_hready(hready[1]), .o_hresp(hresp[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void push(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                                 input logic wr, input logic [2:0] size, input logic [31:0] wdata);
        xfer_t x;
        x.sel = sel; x.trans = trans; x.addr = addr;
        x.wr = wr; x.size = size; x.wdata = wdata;
        q.push_back(x);
    endfunction

    // Reference model: judge one completed beat and update the model memory
    task automatic check_beat(input int d, input xfer_t x, input int waits);
        longint      a;
        int          eff, nb, lo, idx;
        bit          in_range, aligned, valid, err;
        logic [31:0] w;
        if (!(x.sel && x.trans[1])) begin
            chk($sformatf("d%0d_idle_waits", d), waits, 0);
            chk($sformatf("d%0d_idle_resp", d), {30'b0, hresp[d]}, 0);
            return;
        end
        a        = longint'(x.addr);
        in_range = (a >= BASE) && (a < BASE + 4 * DEPTH);
        eff      = (x.size > 2) ? 2 : int'(x.size);
        nb       = 1 << eff;
        aligned  = (a % nb) == 0;
        valid    = in_range && aligned && (x.size <= 2 || !ERR_EN);
        err      = ERR_EN && !valid;
        chk($sformatf("d%0d_waits@%h", d, x.addr), waits, err ? 1 : ws_of[d]);
        chk($sformatf("d%0d_resp@%h", d, x.addr), {30'b0, hresp[d]}, err ? 1 : 0);
        idx = int'((a - BASE) / 4);
        if (!x.wr) begin
            last_rd = hrdata[d];
            if (!err) chk($sformatf("d%0d_rdata@%h", d, x.addr), hrdata[d], valid ? mm[d][idx] : 32'h0);
        end else if (valid) begin
            lo = int'(a % 4);
            w  = mm[d][idx];
            for (int b = lo; b < lo + nb; b++) w[8*b +: 8] = x.wdata[8*b +: 8];
            mm[d][idx] = w;
        end
    endtask

    // Pipelined AHB master: issues the queued transfers back to back
    task automatic run(input int d);
        int n = q.size();
        int a = 0, dp = -1, waits = 0, guard = 0;
        logic rdy;
        data_cycles = 0;
        while ((a < n || dp >= 0) && guard < 2000) begin
            if (a < n) begin
                hsel[d] = q[a].sel; htrans[d] = q[a].trans; haddr[d] = q[a].addr;
                hwrite[d] = q[a].wr; hsize[d] = q[a].size;
                hburst[d] = 3'($urandom_range(0, 7));
            end else begin
                hsel[d] = 1'b0; htrans[d] = 2'b00;
            end
            hwdata[d] = (dp >= 0) ? q[dp].wdata : 32'h0;
            @(negedge clk);
            rdy = hready[d];
            if (dp < 0) begin
                chk($sformatf("d%0d_bus_idle_hready", d), {31'b0, rdy}, 1);
            end else begin
                data_cycles++;
                if (!rdy) waits++;
                else begin
                    check_beat(d, q[dp], waits);
                    waits = 0;
                end
            end
            @(posedge clk); #1;
            if (rdy) begin
                dp = (a < n) ? a : -1;
                if (a < n) a++;
            end
            guard++;
        end
        chk($sformatf("d%0d_run_timeout", d), {31'b0, guard < 2000}, 1);
        hsel[d] = 1'b0; htrans[d] = 2'b00;
        q.delete();
    endtask

    task automatic init_words(input int d);
        for (int w = 0; w < 16; w++)
            push(1, 2'b10, 32'(BASE + 4 * w), 1, 3'd2, $urandom);
        run(d);
    endtask

    task automatic random_mix(input int d, input int cnt);
        logic [31:0] addr;
        logic [2:0]  size;
        int          k, w;
        for (int i = 0; i < cnt; i++) begin
            k = $urandom_range(0, 9);
            w = $urandom_range(0, 15);
            if (k == 0) begin
                case ($urandom_range(0, 2))
                    0: push(0, 2'b10, 32'(BASE + 4 * w), 1'($urandom), 3'd2, $urandom);
                    1: push(1, 2'b00, 32'(BASE + 4 * w), 1'($urandom), 3'd2, $urandom);
                    default: push(1, 2'b01, 32'(BASE + 4 * w), 1'($urandom), 3'd2, $urandom);
                endcase
            end else if (k == 1) begin
                case ($urandom_range(0, 4))
                    0: begin addr = 32'(BASE + 4 * DEPTH + 4 * $urandom_range(0, 7)); size = 3'd2; end
                    1: begin addr = 32'(BASE - 4); size = 3'd2; end
                    2: begin addr = 32'(BASE + 4 * w + 1 + 2 * $urandom_range(0, 1)); size = 3'd1; end
                    3: begin addr = 32'(BASE + 4 * w + $urandom_range(1, 3)); size = 3'd2; end
                    default: begin addr = 32'(BASE + 4 * w); size = 3'd3; end
                endcase
                push(1, 2'b10, addr, 1'($urandom), size, $urandom);
            end else begin
                size = 3'($urandom_range(0, 2));
                addr = 32'(BASE + 4 * w);
                if (size == 0) addr = addr + 32'($urandom_range(0, 3));
                if (size == 1) addr = addr + 32'(2 * $urandom_range(0, 1));
                push(1, $urandom_range(0, 1) ? 2'b11 : 2'b10, addr, 1'($urandom), size, $urandom);
            end
        end
        run(d);
    endtask

    initial begin
        hreset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            hsel[d] = 0; haddr[d] = 0; htrans[d] = 0; hwrite[d] = 0;
            hsize[d] = 0; hburst[d] = 0; hwdata[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d_rst_hready", d), {31'b0, hready[d]}, 1);
            chk($sformatf("d%0d_rst_hresp", d), {30'b0, hresp[d]}, 0);
            chk($sformatf("d%0d_rst_hrdata", d), hrdata[d], 0);
        end
        @(posedge clk); #1;
        hreset = 1'b0;

        // Zero-wait instance
        init_words(0);
        push(1, 2'b10, 32'h8000_0000, 1, 3'd2, 32'hF0FF0FAA);
        push(1, 2'b10, 32'h8000_0000, 0, 3'd2, 32'h0);
        run(0);
        chk("d0_raw_forward", last_rd, 32'hF0FF0FAA);

        push(1, 2'b10, 32'h8000_0004, 1, 3'd2, 32'h1122_3344);
        push(1, 2'b10, 32'h8000_0006, 1, 3'd0, 32'h00AA_0000);
        push(1, 2'b10, 32'h8000_0004, 0, 3'd2, 32'h0);
        run(0);
        chk("d0_byte_merge", last_rd, 32'h11AA_3344);

        push(1, 2'b10, 32'h8000_1000, 1, 3'd2, 32'hDEAD_BEEF);
        push(1, 2'b10, 32'h8000_1000, 0, 3'd2, 32'h0);
        push(1, 2'b10, 32'h8000_0000, 0, 3'd2, 32'h0);
        run(0);

        push(1, 2'b00, 32'h8000_0000, 1, 3'd2, 32'h1111_1111);
        push(1, 2'b01, 32'h8000_0000, 1, 3'd2, 32'h2222_2222);
        push(0, 2'b10, 32'h8000_0000, 1, 3'd2, 32'h3333_3333);
        push(1, 2'b10, 32'h8000_0000, 0, 3'd2, 32'h0);
        run(0);

        random_mix(0, 60);

        // Three-wait-state instance
        init_words(1);
        push(1, 2'b10, 32'h8000_0000, 0, 3'd2, 32'h0);
        run(1);
        push(1, 2'b10, 32'h8000_0000, 0, 3'd2, 32'h0);
        push(1, 2'b11, 32'h8000_0004, 0, 3'd2, 32'h0);
        push(1, 2'b11, 32'h8000_0008, 0, 3'd2, 32'h0);
        push(1, 2'b11, 32'h8000_000C, 0, 3'd2, 32'h0);
        run(1);
        chk("d1_burst_cycles", data_cycles, 16);

        // Reset during the second WAIT cycle of a write
        hsel[1] = 1; htrans[1] = 2'b10; haddr[1] = 32'h8000_0008;
        hwrite[1] = 1; hsize[1] = 3'd2;
        @(posedge clk); #1;
        htrans[1] = 2'b00; hsel[1] = 0; hwdata[1] = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        @(negedge clk);
        chk("d1_wait2_hready", {31'b0, hready[1]}, 0);
        hreset = 1'b1;
        @(posedge clk); #1;
        hreset = 1'b0;
        @(negedge clk);
        chk("d1_midrst_hready", {31'b0, hready[1]}, 1);
        chk("d1_midrst_hresp", {30'b0, hresp[1]}, 0);
        chk("d1_midrst_hrdata", hrdata[1], 0);
        @(posedge clk); #1;
        push(1, 2'b10, 32'h8000_0008, 0, 3'd2, 32'h0);
        run(1);

        random_mix(1, 40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
